// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_pkg
//  Description : Shared types and constants for the operand-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_NREG   = 8;
    localparam int DEFAULT_REG_AW = 3;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        READ_A = 2'b01,
        READ_B = 2'b10,
        DONE   = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/operand_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : operand_shifter
//  Description : Combinational single-bit shifter applied to operand B.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_shifter
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] in,
    input  logic [1:0]        shift,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        out = in;
        case (shift)
            SH_LSL:  out = {in[DATA_W-2:0], 1'b0};
            SH_LSR:  out = {1'b0, in[DATA_W-1:1]};
            SH_ASR:  out = {in[DATA_W-1], in[DATA_W-1:1]};
            default: out = in;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Register file plus read sequencer producing registered ALU
//                operands Ain/Bin with a one-cycle valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREG   = DEFAULT_NREG,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rm,
    input  logic [1:0]        shift,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] sximm5,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_num,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    output logic              valid,
    output logic              busy
);

    state_t            r_state;
    logic [DATA_W-1:0] r_regs [NREG];
    logic [REG_AW-1:0] r_rn;
    logic [REG_AW-1:0] r_rm;
    logic [1:0]        r_shift;
    logic              r_asel;
    logic              r_bsel;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_b_shifted;

    // Write-first: a same-cycle write to the register being read wins.
    assign w_rd_a = (wr_en && (wr_num == r_rn)) ? wr_data : r_regs[r_rn];
    assign w_rd_b = (wr_en && (wr_num == r_rm)) ? wr_data : r_regs[r_rm];

    // B is consumed on the same edge it is read, so the shifter sits
    // directly on the read path rather than behind a separate latch.
    operand_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .in    (w_rd_b),
        .shift (r_shift),
        .out   (w_b_shifted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_rn    <= '0;
            r_rm    <= '0;
            r_shift <= SH_NONE;
            r_asel  <= 1'b0;
            r_bsel  <= 1'b0;
            r_imm   <= '0;
            r_a     <= '0;
            Ain     <= '0;
            Bin     <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (wr_en) begin
                r_regs[wr_num] <= wr_data;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rn    <= rn;
                        r_rm    <= rm;
                        r_shift <= shift;
                        r_asel  <= asel;
                        r_bsel  <= bsel;
                        r_imm   <= sximm5;
                        busy    <= 1'b1;
                        r_state <= READ_A;
                    end
                end
                READ_A: begin
                    r_a     <= w_rd_a;
                    r_state <= READ_B;
                end
                READ_B: begin
                    Ain     <= r_asel ? '0 : r_a;
                    Bin     <= r_bsel ? r_imm : w_b_shifted;
                    valid   <= 1'b1;
                    r_state <= DONE;
                end
                default: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
